// File: rtl/mcp3_afp_pkg.sv
// Shared definitions for the AFP command-tag path.
// Holds the tag pool geometry, the allocator state encodings and the
// tag request struct used between the allocator and its helpers.
package mcp3_afp_pkg;

  localparam int TAG_W    = 9;
  localparam int NUM_TAGS = 512;
  localparam int CNT_W    = 10;   // holds 0..NUM_TAGS

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } afp_state_e;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_req_t;

endpackage

// File: rtl/mcp3_decoder9x512.sv
// 9-to-512 one-hot decoder with enable.
// Ports:
//   en     - when 0 the output is all zeros
//   sel    - index to decode
//   onehot - single bit set at position sel (when en)
module mcp3_decoder9x512
  import mcp3_afp_pkg::*;
(
  input  logic                en,
  input  logic [TAG_W-1:0]    sel,
  output logic [NUM_TAGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/mcp3_prienc512x9.sv
// Lowest-set-bit priority encoder over 512 request bits.
// Built as 16 groups of 32: each group finds its own lowest bit, then the
// lowest non-empty group is selected, which keeps the carry chain short.
// Ports:
//   req - request vector (the allocator feeds ~busy_next)
//   idx - index of the lowest set bit, 0 when none is set
//   any - at least one bit of req is set
module mcp3_prienc512x9
  import mcp3_afp_pkg::*;
(
  input  logic [NUM_TAGS-1:0] req,
  output logic [TAG_W-1:0]    idx,
  output logic                any
);

  localparam int GRP  = 32;
  localparam int NGRP = NUM_TAGS / GRP;
  localparam int GW   = 5;

  logic [NGRP-1:0]         g_any;
  logic [NGRP-1:0][GW-1:0] g_idx;

  generate
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      logic [GRP-1:0] slice;
      logic [GW-1:0]  lo;

      assign slice = req[g*GRP +: GRP];

      // Scan high to low so the lowest set bit is the last one written.
      always_comb begin
        lo = '0;
        for (int i = GRP - 1; i >= 0; i--)
          if (slice[i]) lo = GW'(i);
      end

      assign g_any[g] = |slice;
      assign g_idx[g] = lo;
    end
  endgenerate

  always_comb begin
    idx = '0;
    for (int g = NGRP - 1; g >= 0; g--)
      if (g_any[g]) idx = {4'(g), g_idx[g]};
  end

  assign any = |g_any;

endmodule

// File: rtl/mcp3_tag_allocator512.sv
// Command tag allocator: hands out the lowest free tag of a 512-entry pool
// and retires tags, one allocation and one free per cycle.
// Ports:
//   clock, reset_n          - clock, synchronous active-low reset
//   cfg_enable              - 1 grants tags, 0 quiesces (drain then idle)
//   cfg_max_outstanding     - outstanding limit, 0 blocks every grant
//   alloc_valid/alloc_tag   - registered offer of the lowest free tag
//   alloc_take              - consumer accepts the offer this cycle
//   free_valid/free_tag     - retire a tag
//   busy_count              - tags currently allocated
//   idle                    - quiesced with nothing outstanding
//   err_free_unalloc/err_tag- sticky illegal-free flag and first bad tag
module mcp3_tag_allocator512
  import mcp3_afp_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_enable,
  input  logic [CNT_W-1:0] cfg_max_outstanding,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_take,
  input  logic             free_valid,
  input  logic [TAG_W-1:0] free_tag,
  output logic [CNT_W-1:0] busy_count,
  output logic             idle,
  output logic             err_free_unalloc,
  output logic [TAG_W-1:0] err_tag
);

  logic [NUM_TAGS-1:0] busy, busy_next, free_map;
  logic [NUM_TAGS-1:0] set_mask, clr_mask;
  logic [CNT_W-1:0]    busy_count_next;
  afp_state_e          state, state_next;
  tag_req_t            fr;
  logic                take, clr_hit, bad_free;
  logic                any_free, av_next;
  logic [TAG_W-1:0]    low_free, at_next;

  assign fr.vld = free_valid;
  assign fr.tag = free_tag;

  assign take     = alloc_valid & alloc_take;
  // A free only counts against a tag that is busy now; freeing the tag
  // being taken this same cycle lands here as illegal.
  assign clr_hit  = fr.vld &  busy[fr.tag];
  assign bad_free = fr.vld & ~busy[fr.tag];

  mcp3_decoder9x512 u_dec_set (
    .en     (take),
    .sel    (alloc_tag),
    .onehot (set_mask)
  );

  mcp3_decoder9x512 u_dec_clr (
    .en     (clr_hit),
    .sel    (fr.tag),
    .onehot (clr_mask)
  );

  assign busy_next       = (busy | set_mask) & ~clr_mask;
  assign busy_count_next = busy_count + CNT_W'(take) - CNT_W'(clr_hit);
  assign free_map        = ~busy_next;

  mcp3_prienc512x9 u_prienc (
    .req (free_map),
    .idx (low_free),
    .any (any_free)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (cfg_enable) state_next = ST_RUN;
      ST_RUN:   if (!cfg_enable) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (cfg_enable)                state_next = ST_RUN;
        else if (busy_count_next == '0) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // The offer is keyed off the current state, so leaving IDLE costs one
  // cycle for the state and one for the offer register.
  always_comb begin
    av_next = (state == ST_RUN) & cfg_enable & any_free &
              (busy_count_next < cfg_max_outstanding);
    at_next = any_free ? low_free : alloc_tag;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      busy             <= '0;
      busy_count       <= '0;
      alloc_valid      <= 1'b0;
      alloc_tag        <= '0;
      err_free_unalloc <= 1'b0;
      err_tag          <= '0;
    end else begin
      state       <= state_next;
      busy        <= busy_next;
      busy_count  <= busy_count_next;
      alloc_valid <= av_next;
      alloc_tag   <= at_next;
      if (bad_free && !err_free_unalloc) begin
        err_free_unalloc <= 1'b1;
        err_tag          <= fr.tag;
      end
    end
  end

  assign idle = (state == ST_IDLE);

endmodule

// File: tb/tb_mcp3_tag_allocator512.sv
module tb_mcp3_tag_allocator512;

  logic       clock = 1'b0;
  logic       reset_n, cfg_enable;
  logic [9:0] cfg_max_outstanding;
  logic       alloc_valid, alloc_take, free_valid;
  logic [8:0] alloc_tag, free_tag, err_tag;
  logic [9:0] busy_count;
  logic       idle, err_free_unalloc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mcp3_tag_allocator512 dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .cfg_enable          (cfg_enable),
    .cfg_max_outstanding (cfg_max_outstanding),
    .alloc_valid         (alloc_valid),
    .alloc_tag           (alloc_tag),
    .alloc_take          (alloc_take),
    .free_valid          (free_valid),
    .free_tag            (free_tag),
    .busy_count          (busy_count),
    .idle                (idle),
    .err_free_unalloc    (err_free_unalloc),
    .err_tag             (err_tag)
  );

  typedef struct packed {
    logic       rst_n, en;
    logic [9:0] lim;
    logic       take, fv;
    logic [8:0] ft;
    logic       av;
    logic [8:0] at;
    logic [9:0] cnt;
    logic       idl, err;
    logic [8:0] etag;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(logic rst_n, logic en, logic [9:0] lim,
                              logic take, logic fv, logic [8:0] ft,
                              logic av, logic [8:0] at, logic [9:0] cnt,
                              logic idl, logic err, logic [8:0] etag);
    vec_t v;
    v = {rst_n, en, lim, take, fv, ft, av, at, cnt, idl, err, etag};
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic rst, input logic en, input logic [9:0] lim,
                      input logic take, input logic fv, input logic [8:0] ft);
    reset_n = rst; cfg_enable = en; cfg_max_outstanding = lim;
    alloc_take = take; free_valid = fv; free_tag = ft;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             rst en  lim  tk fv ft    av at   cnt idl err etag
    tbl[0]  = mk(0, 0, 512, 0, 0, 0,   0, 0,   0,  1,  0,  0);
    tbl[1]  = mk(1, 1, 512, 0, 0, 0,   0, 0,   0,  0,  0,  0);
    tbl[2]  = mk(1, 1, 512, 0, 0, 0,   1, 0,   0,  0,  0,  0);
    tbl[3]  = mk(1, 1, 512, 1, 0, 0,   1, 1,   1,  0,  0,  0);
    tbl[4]  = mk(1, 1, 512, 1, 0, 0,   1, 2,   2,  0,  0,  0);
    tbl[5]  = mk(1, 1, 512, 1, 0, 0,   1, 3,   3,  0,  0,  0);
    tbl[6]  = mk(1, 1, 512, 1, 0, 0,   1, 4,   4,  0,  0,  0);
    tbl[7]  = mk(1, 1, 512, 1, 1, 1,   1, 1,   4,  0,  0,  0);   // take 4, free 1
    tbl[8]  = mk(1, 1, 512, 0, 1, 100, 1, 1,   4,  0,  1,  100); // illegal free
    tbl[9]  = mk(1, 1, 512, 0, 1, 200, 1, 1,   4,  0,  1,  100); // second keeps tag
    tbl[10] = mk(1, 1, 512, 1, 1, 1,   1, 5,   5,  0,  1,  100); // free of tag being taken
    tbl[11] = mk(1, 1, 5,   0, 0, 0,   0, 5,   5,  0,  1,  100); // at limit
    tbl[12] = mk(1, 1, 5,   1, 0, 0,   0, 5,   5,  0,  1,  100); // take ignored
    tbl[13] = mk(1, 1, 5,   0, 1, 0,   1, 0,   4,  0,  1,  100);
    tbl[14] = mk(1, 1, 3,   0, 0, 0,   0, 0,   4,  0,  1,  100); // lower limit, no revoke
    tbl[15] = mk(1, 1, 3,   0, 1, 4,   0, 0,   3,  0,  1,  100);
    tbl[16] = mk(1, 1, 3,   0, 1, 3,   1, 0,   2,  0,  1,  100);
    tbl[17] = mk(1, 0, 3,   1, 0, 0,   0, 3,   3,  0,  1,  100); // enable drops, take honoured
    tbl[18] = mk(1, 0, 3,   1, 0, 0,   0, 3,   3,  0,  1,  100);
    tbl[19] = mk(1, 0, 3,   0, 1, 0,   0, 0,   2,  0,  1,  100);
    tbl[20] = mk(1, 0, 3,   0, 1, 1,   0, 0,   1,  0,  1,  100);
    tbl[21] = mk(1, 0, 3,   0, 1, 2,   0, 0,   0,  1,  1,  100); // drained
    tbl[22] = mk(1, 1, 3,   0, 0, 0,   0, 0,   0,  0,  1,  100);
    tbl[23] = mk(1, 1, 3,   0, 0, 0,   1, 0,   0,  0,  1,  100);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].lim, tbl[i].take, tbl[i].fv, tbl[i].ft);
      chk("alloc_valid", i, 32'(alloc_valid),      32'(tbl[i].av));
      chk("alloc_tag",   i, 32'(alloc_tag),        32'(tbl[i].at));
      chk("busy_count",  i, 32'(busy_count),       32'(tbl[i].cnt));
      chk("idle",        i, 32'(idle),             32'(tbl[i].idl));
      chk("err_flag",    i, 32'(err_free_unalloc), 32'(tbl[i].err));
      chk("err_tag",     i, 32'(err_tag),          32'(tbl[i].etag));
    end

    // Reset mid-operation abandons outstanding tags and clears the error.
    step(0, 1, 512, 0, 0, 0);
    chk("rst_count", 0, 32'(busy_count),       0);
    chk("rst_valid", 0, 32'(alloc_valid),      0);
    chk("rst_err",   0, 32'(err_free_unalloc), 0);
    chk("rst_idle",  0, 32'(idle),             1);

    // Fill the whole pool with take held high.
    step(1, 1, 512, 0, 0, 0);
    chk("fill_lat1", 0, 32'(alloc_valid), 0);
    step(1, 1, 512, 0, 0, 0);
    for (int t = 0; t < 512; t++) begin
      chk("fill_valid", t, 32'(alloc_valid), 1);
      chk("fill_tag",   t, 32'(alloc_tag),   32'(t));
      step(1, 1, 512, 1, 0, 0);
    end
    chk("full_valid", 0, 32'(alloc_valid), 0);
    chk("full_count", 0, 32'(busy_count),  512);
    chk("full_tag",   0, 32'(alloc_tag),   511);
    step(1, 1, 512, 1, 0, 0);
    chk("full_hold",  0, 32'(busy_count),  512);
    step(1, 1, 512, 0, 1, 37);
    chk("f37_valid", 0, 32'(alloc_valid), 1);
    chk("f37_tag",   0, 32'(alloc_tag),   37);
    chk("f37_count", 0, 32'(busy_count),  511);
    step(1, 1, 512, 1, 0, 0);
    chk("r37_valid", 0, 32'(alloc_valid), 0);
    chk("r37_count", 0, 32'(busy_count),  512);

    // Limit of 2.
    step(0, 1, 2, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0);
    chk("lim_valid0", 0, 32'(alloc_valid), 1);
    step(1, 1, 2, 1, 0, 0);
    chk("lim_tag1",   0, 32'(alloc_tag),   1);
    chk("lim_valid1", 0, 32'(alloc_valid), 1);
    step(1, 1, 2, 1, 0, 0);
    chk("lim_valid2", 0, 32'(alloc_valid), 0);
    chk("lim_count2", 0, 32'(busy_count),  2);
    step(1, 1, 2, 0, 1, 0);
    chk("lim_valid3", 0, 32'(alloc_valid), 1);
    chk("lim_tag3",   0, 32'(alloc_tag),   0);
    chk("lim_count3", 0, 32'(busy_count),  1);

    // Limit of 0 blocks every grant.
    step(1, 1, 0, 0, 0, 0);
    chk("lim0_valid", 0, 32'(alloc_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcp3_tag_allocator512.md
Name: mcp3_tag_allocator512

Overview:
- Allocates and retires 9-bit command tags from a 512-entry pool, one allocation and one free per cycle.
- Sits between the AFP command engine and the response tracker.
- Tracks a 512-bit busy bitmap, edited by one-hot masks from a 9-to-512 decoder.
- Offers the lowest-numbered free tag, honours a programmable outstanding limit, and supports quiesce/drain for reconfiguration.

Parameters:
- NUM_TAGS, 512, pool size; fixed, since the decoder is 9x512.
- TAG_W, 9, tag width.
- CNT_W, 10, counter width; must hold 0..512.

Ports:
- clock  in  1  sole clock.
- reset_n  in  1  synchronous, active-low reset.
- cfg_enable  in  1  1 = grant tags; 0 = quiesce.
- cfg_max_outstanding  in  10  outstanding-tag limit, 0..512; 0 blocks all grants.
- alloc_valid  out  1  alloc_tag is offered.
- alloc_tag  out  9  lowest free tag.
- alloc_take  in  1  consumer accepts alloc_tag this cycle; ignored unless alloc_valid.
- free_valid  in  1  retire free_tag this cycle.
- free_tag  in  9  tag being retired.
- busy_count  out  10  number of tags currently allocated.
- idle  out  1  state IDLE (quiesced and busy_count==0).
- err_free_unalloc  out  1  sticky: a free targeted a non-busy tag.
- err_tag  out  9  tag of the first offending free.

Behaviour:
- Reset, sampled on the clock edge while reset_n==0:
  - busy bitmap, busy_count, err_free_unalloc and err_tag all cleared.
  - alloc_valid=0, alloc_tag=0, state=IDLE, idle=1.
  - A reset mid-operation abandons every outstanding tag.
- Handshake: take = alloc_valid & alloc_take.
- Bitmap update each cycle:
  - set_mask = take ? dec(alloc_tag) : 0
  - clr_mask = (free_valid & busy[free_tag]) ? dec(free_tag) : 0
  - busy_next = (busy | set_mask) & ~clr_mask
- busy_count_next = busy_count + take - (clr_mask!=0). Simultaneous take and legal free leave the count unchanged.
- Next offer, registered and computed from busy_next:
  - alloc_valid_next = (state==RUN) & cfg_enable & (busy_next != all-ones) & (busy_count_next < cfg_max_outstanding)
  - alloc_tag_next = lowest index i with busy_next[i]==0. Hold the previous alloc_tag when there is no free tag.
- Latency:
  - back-to-back takes every cycle are supported;
  - a tag freed in cycle N is offerable in cycle N+1;
  - the first offer appears 2 cycles after reset_n rises with cfg_enable=1 (IDLE->RUN, then register).
- Illegal free (free_valid with busy[free_tag]==0):
  - bitmap and count unchanged;
  - err_free_unalloc set; err_tag captured only on the first error;
  - cleared only by reset.
  - Freeing the tag being taken in the same cycle is illegal, because the tag is not yet busy.
- Lowering cfg_max_outstanding below busy_count never revokes tags. It only suppresses alloc_valid until frees bring the count under the limit.
- State machine (2-bit):
  - IDLE: alloc_valid=0. Go to RUN when cfg_enable=1.
  - RUN: offers as above. Go to DRAIN when cfg_enable=0.
  - DRAIN: alloc_valid=0 and frees still processed. Go to IDLE when busy_count_next==0. Go to RUN if cfg_enable returns to 1.
- Deassertion of alloc_valid takes effect the cycle after cfg_enable falls. An alloc_take in that same cycle against a still-valid offer is honoured.
- Full pool (busy_count==512): alloc_valid=0; any legal free re-enables the offer next cycle.

Decomposition:
- Shared package mcp3_afp_pkg holds:
  - TAG_W=9, NUM_TAGS=512, CNT_W=10;
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2.
- Instantiate the existing mcp3_decoder9x512 twice (set mask, clear mask).
- One new sub-module, mcp3_prienc512x9: combinational lowest-set-bit encoder over ~busy_next, with an any_free output. Build it hierarchically as 16 groups of 32.

Test Plan:
- Reset, enable=1, limit=512, take held high -> alloc_valid=1 from cycle 2; tags 0,1,2,...,511 on consecutive cycles; then alloc_valid=0 and busy_count=512.
- Pool full; free tag 37 -> next cycle alloc_valid=1, alloc_tag=37; take it -> alloc_valid=0, busy_count=512.
- Allocate tags 0..3; free tag 1 while taking tag 4 -> busy_count stays 4; next offer is alloc_tag=1.
- limit=2; take 0 and 1 -> alloc_valid=0 at busy_count=2; free 0 -> offer alloc_tag=0.
- Free tag 100 while it is not busy -> err_free_unalloc=1, err_tag=100, busy_count unchanged; a second illegal free of 200 leaves err_tag=100.
- Hold 3 tags; drop cfg_enable -> alloc_valid=0 next cycle, idle=0; free all 3 -> idle=1 one cycle after the last free; reassert enable -> offer alloc_tag=0 two cycles later.
